data_memory_responder: RTL

Memory-side responder for the core's load/store interface. It sits between the pipeline's memory request outputs and a local byte-addressable word RAM, and returns read data with a valid strobe. Stores commit in the cycle they are sampled. Loads are serviced after a fixed, parameterised latency, with byte/half/word lane selection and sign or zero extension. Instruction fetches and data loads use the same load path.

---
 rtl/data_memory_responder_if.sv | 25 ++
 rtl/data_memory_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// Pipeline-to-memory load/store channel: request fields from the core, response/status back from the responder.
interface data_memory_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] memoryAddress;
  logic [DATA_WIDTH-1:0] memoryDataWrite;
  logic [1:0]            memoryLength;
  logic                  store;
  logic                  load;
  logic                  loadUnsigned;
  logic [DATA_WIDTH-1:0] memoryDataRead;
  logic                  memoryReadValid;
  logic                  accessError;
  logic                  busy;

  modport master (
    output memoryAddress, memoryDataWrite, memoryLength, store, load, loadUnsigned,
    input  memoryDataRead, memoryReadValid, accessError, busy
  );

  modport slave (
    input  memoryAddress, memoryDataWrite, memoryLength, store, load, loadUnsigned,
    output memoryDataRead, memoryReadValid, accessError, busy
  );
endinterface

// File: rtl/data_memory_responder.sv
// Load/store responder over a local byte-addressed word RAM: stores commit at the sampling edge, loads
// answer READ_LATENCY cycles after acceptance; no backpressure, loads arriving while busy are dropped.
module data_memory_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int READ_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_memory_responder_if.slave mem
);
  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} responderState;

  localparam int         WORDS        = 1 << MEM_WORDS_LOG2;
  localparam logic [3:0] LATENCY_INIT = 4'(READ_LATENCY - 1);

  responderState state, nextState;
  logic [3:0]    latencyCount;
  logic [31:0]   ram [WORDS];

  logic [MEM_WORDS_LOG2-1:0] wordIndex;
  logic [1:0]  byteLane;
  logic        outOfRange, misaligned, requestError;
  logic        storeEnable, loadAccept;
  logic [3:0]  laneEnable;
  logic [31:0] writeData, laneShifted, loadExtended, loadResult;
  logic [31:0] pendingData, readDataQ;
  logic        pendingError, storeErrorQ;

  assign wordIndex    = mem.memoryAddress[MEM_WORDS_LOG2+1:2];
  assign byteLane     = mem.memoryAddress[1:0];
  assign outOfRange   = |mem.memoryAddress[DATA_WIDTH-1:MEM_WORDS_LOG2+2];
  assign requestError = outOfRange || misaligned;

  // RESPOND is the only state that ignores stores; loads are only taken from IDLE and lose to a store.
  assign storeEnable = mem.store && !requestError && (state != RESPOND);
  assign loadAccept  = (state == IDLE) && mem.load && !mem.store;

  always_comb begin
    misaligned = 1'b0;
    case (mem.memoryLength)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = byteLane[0];
      default: misaligned = (byteLane != 2'b00);
    endcase
  end

  // Replicating right-aligned store data across lanes lets the lane enables pick the target bytes.
  always_comb begin
    laneEnable = 4'b1111;
    writeData  = mem.memoryDataWrite;
    case (mem.memoryLength)
      2'd0: begin
        laneEnable = 4'b0001 << byteLane;
        writeData  = {4{mem.memoryDataWrite[7:0]}};
      end
      2'd1: begin
        laneEnable = 4'b0011 << byteLane;
        writeData  = {2{mem.memoryDataWrite[15:0]}};
      end
      default: begin
        laneEnable = 4'b1111;
        writeData  = mem.memoryDataWrite;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (storeEnable) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (laneEnable[lane]) ram[wordIndex][lane*8 +: 8] <= writeData[lane*8 +: 8];
      end
    end
  end

  assign laneShifted = ram[wordIndex] >> {byteLane, 3'b000};

  always_comb begin
    loadExtended = laneShifted;
    case (mem.memoryLength)
      2'd0:    loadExtended = {{24{laneShifted[7] & ~mem.loadUnsigned}}, laneShifted[7:0]};
      2'd1:    loadExtended = {{16{laneShifted[15] & ~mem.loadUnsigned}}, laneShifted[15:0]};
      default: loadExtended = laneShifted;
    endcase
  end

  assign loadResult = requestError ? '0 : loadExtended;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (loadAccept) nextState = (READ_LATENCY == 1) ? RESPOND : WAIT;
      WAIT:    if (latencyCount == 4'd0) nextState = RESPOND;
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latencyCount <= 4'd0;
      pendingData  <= '0;
      pendingError <= 1'b0;
      readDataQ    <= '0;
      storeErrorQ  <= 1'b0;
    end else begin
      storeErrorQ <= mem.store && requestError && (state != RESPOND);
      if (loadAccept) begin
        latencyCount <= LATENCY_INIT;
        pendingData  <= loadResult;
        pendingError <= requestError;
      end else if (state == WAIT && latencyCount != 4'd0) begin
        latencyCount <= latencyCount - 4'd1;
      end
      // With single-cycle latency the response is entered on the accepting edge, before pendingData lands.
      if (nextState == RESPOND && state != RESPOND) readDataQ <= loadAccept ? loadResult : pendingData;
    end
  end

  always_comb begin
    mem.memoryReadValid = (state == RESPOND);
    mem.busy            = (state == WAIT);
    mem.accessError     = storeErrorQ || ((state == RESPOND) && pendingError);
  end

  assign mem.memoryDataRead = readDataQ;
endmodule
